// File: rtl/seg_pattern_decoder_if.sv
// ============================================================================
// Module   : seg_pattern_decoder_if
// Brief    : Valid/ready output channel carrying decoded 7-segment events.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seg_pattern_decoder_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_blank;
    logic       out_err;

    modport master (
        output out_valid,
        output out_digit,
        output out_blank,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digit,
        input  out_blank,
        input  out_err,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/seg_pattern_decoder.sv
// ============================================================================
// Module   : seg_pattern_decoder
// Brief    : Debounces an asynchronous 7-segment bus and emits each new stable
//            pattern as a hex digit event. SEG_ERR_CNT_EN enables err_cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [6:0]           seg,
    seg_pattern_decoder_if.master     out_if,
    output logic      [CNT_W-1:0]     err_cnt
);

    localparam int             CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  STABLE_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [6:0]      s1;
    logic [6:0]      s2;
    logic [6:0]      cand;
    logic [CW-1:0]   cnt;
    logic [6:0]      last_rpt;
    logic [3:0]      digit;
    logic            blank;
    logic            err;
    logic            load;
    logic            handshake;
    logic [3:0]      dec_digit;
    logic            dec_blank;
    logic            dec_err;

    // Two-flop synchronizer followed by the stability tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 7'h00;
            s2   <= 7'h00;
            cand <= 7'h00;
            cnt  <= STABLE_MAX;
        end else begin
            s1 <= seg;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= CW'(1);
            end else if (cnt < STABLE_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        dec_digit = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (cand)
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h07: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h6F: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h39: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h79: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    assign handshake = (state == ST_EMIT) && out_if.out_ready;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_WAIT: begin
                if ((cnt == STABLE_MAX) && (cand != last_rpt)) begin
                    state_nxt = ST_EMIT;
                    load      = 1'b1;
                end
            end
            ST_EMIT: begin
                if (handshake) begin
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

    // Reset drops out_valid immediately since it is a pure decode of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT;
            last_rpt <= 7'h00;
            digit    <= 4'h0;
            blank    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                last_rpt <= cand;
                digit    <= dec_digit;
                blank    <= dec_blank;
                err      <= dec_err;
            end
        end
    end

    assign out_if.out_valid = (state == ST_EMIT);
    assign out_if.out_digit = digit;
    assign out_if.out_blank = blank;
    assign out_if.out_err   = err;

`ifdef SEG_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (handshake && err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg_pattern_decoder.sv
// ============================================================================
// Module   : tb_seg_pattern_decoder
// Brief    : Directed self-checking bench for seg_pattern_decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_pattern_decoder;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [6:0]       seg;
    logic [CNT_W-1:0] err_cnt;
    int               checks;
    int               failures;
    bit               ok;
    bit               seen;
    bit               early;
    logic [31:0]      exp_cnt1;

    seg_pattern_decoder_if bus ();

    seg_pattern_decoder #(
        .STABLE_CYCLES (4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg),
        .out_if  (bus.master),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) found = 1'b1;
        end
    endtask

    task automatic watch_valid(input int n, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) hit = 1'b1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
`ifdef SEG_ERR_CNT_EN
        exp_cnt1 = 32'd1;
`else
        exp_cnt1 = 32'd0;
`endif
        rst_n         = 1'b0;
        seg           = 7'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_digit", 32'(bus.out_digit), 32'd0);
        chk("rst_flags", {30'd0, bus.out_blank, bus.out_err}, 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);

        // Start-up blank must not produce an event.
        @(negedge clk);
        rst_n = 1'b1;
        watch_valid(20, seen);
        chk("idle_no_event", 32'(seen), 32'd0);
        chk("idle_digit", 32'(bus.out_digit), 32'd0);
        chk("idle_flags", {30'd0, bus.out_blank, bus.out_err}, 32'd0);

        // Exact latency: valid after edge 7, high for one cycle.
        bus.out_ready = 1'b1;
        @(negedge clk);
        seg = 7'h5B;
        watch_valid(6, early);
        chk("lat_not_early", 32'(early), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_e7", 32'(bus.out_valid), 32'd1);
        chk("lat_digit", 32'(bus.out_digit), 32'd2);
        chk("lat_flags", {30'd0, bus.out_blank, bus.out_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_one_cycle", 32'(bus.out_valid), 32'd0);

        // Short glitch back to the reported pattern: no event.
        @(negedge clk);
        seg = 7'h06;
        @(negedge clk);
        @(negedge clk);
        seg = 7'h5B;
        watch_valid(20, seen);
        chk("glitch_no_event", 32'(seen), 32'd0);
        @(negedge clk);
        seg = 7'h4F;
        wait_valid(20, ok);
        chk("d3_timeout", 32'(ok), 32'd1);
        chk("d3_digit", 32'(bus.out_digit), 32'd3);
        @(posedge clk);
        #1;
        chk("d3_drop", 32'(bus.out_valid), 32'd0);

        // Backpressure: first event held, middle pattern coalesced.
        @(negedge clk);
        bus.out_ready = 1'b0;
        seg = 7'h66;
        repeat (10) @(negedge clk);
        chk("bp_valid_66", 32'(bus.out_valid), 32'd1);
        chk("bp_digit_66", 32'(bus.out_digit), 32'd4);
        seg = 7'h6D;
        repeat (10) @(negedge clk);
        chk("bp_hold_6d", {27'd0, bus.out_valid, bus.out_digit}, {27'd0, 1'b1, 4'h4});
        seg = 7'h7D;
        repeat (10) @(negedge clk);
        chk("bp_hold_7d", {27'd0, bus.out_valid, bus.out_digit}, {27'd0, 1'b1, 4'h4});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_drop", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_digit", 32'(bus.out_digit), 32'd6);
        @(posedge clk);
        #1;
        chk("bp_next_drop", 32'(bus.out_valid), 32'd0);

        // Illegal pattern then blank.
        @(negedge clk);
        seg = 7'h12;
        wait_valid(20, ok);
        chk("err_timeout", 32'(ok), 32'd1);
        chk("err_flag", 32'(bus.out_err), 32'd1);
        chk("err_digit", 32'(bus.out_digit), 32'd0);
        chk("err_blank", 32'(bus.out_blank), 32'd0);
        @(posedge clk);
        #1;
        chk("err_cnt_after", 32'(err_cnt), exp_cnt1);
        @(negedge clk);
        seg = 7'h00;
        wait_valid(20, ok);
        chk("blank_timeout", 32'(ok), 32'd1);
        chk("blank_flag", 32'(bus.out_blank), 32'd1);
        chk("blank_err", 32'(bus.out_err), 32'd0);
        chk("blank_digit", 32'(bus.out_digit), 32'd0);
        @(posedge clk);
        #1;
        chk("blank_errcnt", 32'(err_cnt), exp_cnt1);

        // Asynchronous reset while an event is pending.
        @(negedge clk);
        bus.out_ready = 1'b0;
        seg = 7'h5B;
        wait_valid(20, ok);
        chk("arst_pre_valid", 32'(ok), 32'd1);
        chk("arst_pre_digit", 32'(bus.out_digit), 32'd2);
        #2;
        rst_n = 1'b0;
        seg   = 7'h00;
        #1;
        chk("arst_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("arst_errcnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        watch_valid(20, seen);
        chk("arst_no_replay", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
